dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 3, array access wait cycles (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of word count (words indexed by addr[DEPTH_LOG2+1:2]).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_read  input  1  MEM-stage load request.
REQ-006 SHALL have port mem_write  input  1  MEM-stage store request.
REQ-007 SHALL have port addr  input  32  byte address (ALU result).
REQ-008 SHALL have port wdata  input  32  raw store data (rt value, unaligned).
REQ-009 SHALL have port be  input  4  byte enables; bit k = byte lane k (bits 8k+7:8k).
REQ-010 SHALL have port ext_sh  input  3  load type: 000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; others treated as lw.
REQ-011 SHALL have port stall  output  1  freeze pipeline registers up to and including MEM/WB input.
REQ-012 SHALL have port rdata  output  32  extended load result, registered.
REQ-013 SHALL have port rdata_valid  output  1  one-cycle pulse when rdata updated by a load.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL, in IDLE with mem_read or mem_write high, latch addr, wdata, be, ext_sh, request type; load counter with LATENCY-1; go BUSY.
REQ-016 SHALL drive stall combinationally = (IDLE and (mem_read or mem_write)) or BUSY; stall 0 in DONE.
REQ-017 SHALL decrement counter each BUSY cycle; at counter 0 perform array access and go DONE (BUSY lasts exactly LATENCY cycles).
REQ-018 SHALL, in DONE, ignore all request inputs and return to IDLE next cycle (requester advances on the DONE edge).
REQ-019 SHALL give total stall of LATENCY+1 cycles per request; back-to-back requests incur no extra idle cycle beyond DONE.
REQ-020 SHALL, when both mem_read and mem_write are high, perform the write only; no rdata_valid pulse.
REQ-021 SHALL build store word by be popcount: 1 bit -> {4{wdata[7:0]}}, 2 bits -> {2{wdata[15:0]}}, 4 bits -> wdata; write only lanes with be bit set.
REQ-022 SHALL treat be=0000 on a write as no-op with normal timing.
REQ-023 SHALL select load byte by latched addr[1:0], halfword by addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes word.
REQ-024 SHALL register extended data into rdata on the BUSY->DONE edge; rdata_valid high during DONE only for reads.
REQ-025 SHALL hold rdata unchanged except on load completion.
REQ-026 SHALL treat addr[31:DEPTH_LOG2+2] nonzero as out-of-range: write dropped, read returns 0, timing unchanged.
REQ-027 SHALL not clear array contents (array uninitialised after power-up).

Reset
REQ-028 SHALL, with reset high, force state IDLE, counter 0, rdata 0, rdata_valid 0, stall 0 (reset overrides REQ-016).
REQ-029 SHALL, on reset during BUSY, abort the request; pending write NOT committed; DONE not entered.
REQ-030 SHALL accept a request present in the first cycle after reset deasserts.

Verification
REQ-031 SHALL verify sw: addr 0x10, wdata 0xDEADBEEF, be 1111, LATENCY 3 -> stall high 4 cycles; later lw 0x10 -> rdata 0xDEADBEEF, rdata_valid 1 cycle.
REQ-032 SHALL verify sb addr 0x13 wdata 0x000000A5 be 1000 over word 0x11223344 -> lw gives 0xA5223344; lb 0x13 -> 0xFFFFFFA5; lbu -> 0x000000A5.
REQ-033 SHALL verify sh addr 0x22 wdata 0x8001 be 1100 -> lh 0x22 -> 0xFFFF8001; lhu -> 0x00008001.
REQ-034 SHALL verify reset asserted on 2nd BUSY cycle of sw 0x30 value 0x55 over old 0x0 -> stall 0 next cycle; lw 0x30 returns 0x0.
REQ-035 SHALL verify back-to-back lw/lw held by stall -> each request stalls exactly LATENCY+1 cycles, two rdata_valid pulses LATENCY+2 cycles apart.
REQ-036 SHALL verify out-of-range lw addr 0x00010000 -> rdata 0, normal timing; mem_read+mem_write together -> write committed, no rdata_valid.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory response block: stalls the pipeline for a fixed access latency,
// performs byte-lane stores and sign/zero-extended loads against an inferred RAM.
module dmem_resp #(
  parameter int LATENCY    = 3,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic [2:0]  ext_sh,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT       stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic [31:0] addrReg, wdataReg;
  logic [3:0]  beReg;
  logic [2:0]  extReg;
  logic        isReadReg, isWriteReg;

  logic                  accept, access, outOfRange;
  logic [DEPTH_LOG2-1:0] reqIdx, latIdx;
  logic [2:0]            beCount;
  logic [31:0]           storeWord, ramWord, loadVal;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;

  assign accept     = (stateReg == IDLE) && (mem_read || mem_write);
  assign access     = (stateReg == BUSY) && (cntReg == '0);
  assign outOfRange = |addrReg[31:DEPTH_LOG2+2];
  assign reqIdx     = addr[DEPTH_LOG2+1:2];
  assign latIdx     = addrReg[DEPTH_LOG2+1:2];

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    stall     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (mem_read || mem_write) begin
          stall     = 1'b1;
          stateNext = BUSY;
          cntNext   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cntReg == '0) stateNext = DONE;
        else              cntNext   = cntReg - 4'd1;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Reset wins over the request-driven stall so the pipeline is never frozen in reset.
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      cntReg      <= cntNext;
      rdata_valid <= access && isReadReg;
      if (access && isReadReg) rdata <= outOfRange ? 32'h0 : loadVal;
    end
  end

  // Request capture; plain datapath registers, only meaningful once a request is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      addrReg    <= addr;
      wdataReg   <= wdata;
      beReg      <= be;
      extReg     <= ext_sh;
      isReadReg  <= mem_read && !mem_write;
      isWriteReg <= mem_write;
    end
  end

  assign beCount = {2'b00, beReg[0]} + {2'b00, beReg[1]} + {2'b00, beReg[2]} + {2'b00, beReg[3]};

  always_comb begin
    case (beCount)
      3'd1:    storeWord = {4{wdataReg[7:0]}};
      3'd2:    storeWord = {2{wdataReg[15:0]}};
      default: storeWord = wdataReg;
    endcase
  end

  // One RAM per byte lane so each lane has its own write enable; the raw word is read
  // at acceptance so it is ready for extension when the access completes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];
      logic [7:0] laneQ;
      always_ff @(posedge clk) begin
        if (access && isWriteReg && !reset && !outOfRange && beReg[gi])
          laneMem[latIdx] <= storeWord[8*gi +: 8];
        if (accept) laneQ <= laneMem[reqIdx];
      end
      assign ramWord[8*gi +: 8] = laneQ;
    end
  endgenerate

  always_comb begin
    case (addrReg[1:0])
      2'd0:    byteSel = ramWord[7:0];
      2'd1:    byteSel = ramWord[15:8];
      2'd2:    byteSel = ramWord[23:16];
      default: byteSel = ramWord[31:24];
    endcase
    halfSel = addrReg[1] ? ramWord[31:16] : ramWord[15:0];
    case (extReg)
      3'b001:  loadVal = {24'h0, byteSel};
      3'b010:  loadVal = {{24{byteSel[7]}}, byteSel};
      3'b011:  loadVal = {16'h0, halfSel};
      3'b100:  loadVal = {{16{halfSel[15]}}, halfSel};
      default: loadVal = ramWord;
    endcase
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: scoreboard of expected load data, stall-length
// and pulse-spacing checks, reset abort and out-of-range behaviour.
module tb_dmem_resp;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [2:0]  ext_sh;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;

  int          nAssert = 0;
  int          nFail   = 0;
  int          cyc     = 0;
  int          lastValidCycle = 0;
  logic [31:0] modelRdata = 32'h0;
  logic [31:0] expQ [$];

  dmem_resp #(.LATENCY(LAT), .DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .be(be), .ext_sh(ext_sh),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (caller is just after a rising edge, DUT in IDLE), count stall
  // cycles, check the DONE cycle and return just after the edge leaving DONE.
  task automatic doReq(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic [2:0] e,
                       input logic [31:0] expData, input bit hold);
    int          stallCycles = 0;
    int          guard = 0;
    logic [31:0] exp;
    if (rd && !wr) expQ.push_back(expData);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; be = b; ext_sh = e;
    @(negedge clk);
    while (stall === 1'b1 && guard < 40) begin
      stallCycles++;
      guard++;
      @(negedge clk);
    end
    chk({tag, " stall_cycles"}, 32'(stallCycles), 32'(LAT + 1));
    chk({tag, " valid"}, {31'h0, rdata_valid}, {31'h0, rd && !wr});
    if (rdata_valid === 1'b1) begin
      lastValidCycle = cyc;
      if (expQ.size() == 0) begin
        chk({tag, " unexpected_pulse"}, 32'h1, 32'h0);
      end else begin
        exp = expQ.pop_front();
        chk({tag, " rdata"}, rdata, exp);
        modelRdata = exp;
      end
    end else begin
      if (rd && !wr && expQ.size() != 0) void'(expQ.pop_front());
      chk({tag, " rdata_hold"}, rdata, modelRdata);
    end
    $display("txn %-14s rd=%0b wr=%0b addr=0x%08h wdata=0x%08h be=%b ext=%b stall=%0d rdata=0x%08h",
             tag, rd, wr, a, wd, b, e, stallCycles, rdata);
    @(posedge clk);
    #1;
    if (!hold) begin
      mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  initial begin
    int v1;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata = '0; be = '0; ext_sh = '0;
    repeat (3) @(posedge clk);
    #1 mem_read = 1'b1;
    @(negedge clk);
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset valid", {31'h0, rdata_valid}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0; mem_read = 1'b0;

    doReq("sw10", 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 3'b000, 32'h0, 0);
    doReq("lw10", 1, 0, 32'h10, 32'h0, 4'b1111, 3'b000, 32'hDEADBEEF, 0);
    doReq("sw10b", 0, 1, 32'h10, 32'h11223344, 4'b1111, 3'b000, 32'h0, 0);
    doReq("sb13", 0, 1, 32'h13, 32'h000000A5, 4'b1000, 3'b000, 32'h0, 0);
    doReq("lw10_sb", 1, 0, 32'h10, 32'h0, 4'b1111, 3'b000, 32'hA5223344, 0);
    doReq("lb13", 1, 0, 32'h13, 32'h0, 4'b1111, 3'b010, 32'hFFFFFFA5, 0);
    doReq("lbu13", 1, 0, 32'h13, 32'h0, 4'b1111, 3'b001, 32'h000000A5, 0);
    doReq("sh22", 0, 1, 32'h22, 32'h00008001, 4'b1100, 3'b000, 32'h0, 0);
    doReq("lh22", 1, 0, 32'h22, 32'h0, 4'b1111, 3'b100, 32'hFFFF8001, 0);
    doReq("lhu22", 1, 0, 32'h22, 32'h0, 4'b1111, 3'b011, 32'h00008001, 0);
    doReq("lb23", 1, 0, 32'h23, 32'h0, 4'b1111, 3'b010, 32'hFFFFFF80, 0);
    doReq("lbu22", 1, 0, 32'h22, 32'h0, 4'b1111, 3'b001, 32'h00000001, 0);
    doReq("sw_be0", 0, 1, 32'h10, 32'h00000000, 4'b0000, 3'b000, 32'h0, 0);
    doReq("lw10_be0", 1, 0, 32'h10, 32'h0, 4'b1111, 3'b000, 32'hA5223344, 0);

    doReq("b2b_lw10", 1, 0, 32'h10, 32'h0, 4'b1111, 3'b000, 32'hA5223344, 1);
    v1 = lastValidCycle;
    doReq("b2b_lhu22", 1, 0, 32'h22, 32'h0, 4'b1111, 3'b011, 32'h00008001, 0);
    chk("b2b pulse_gap", 32'(lastValidCycle - v1), 32'(LAT + 2));

    doReq("sw0", 0, 1, 32'h0, 32'hCAFEF00D, 4'b1111, 3'b000, 32'h0, 0);
    doReq("lw_oor", 1, 0, 32'h00010000, 32'h0, 4'b1111, 3'b000, 32'h0, 0);
    doReq("sw_oor", 0, 1, 32'h00010000, 32'h12345678, 4'b1111, 3'b000, 32'h0, 0);
    doReq("lw0", 1, 0, 32'h0, 32'h0, 4'b1111, 3'b000, 32'hCAFEF00D, 0);
    doReq("rdwr40", 1, 1, 32'h40, 32'h600DF00D, 4'b1111, 3'b000, 32'h0, 0);
    doReq("lw40", 1, 0, 32'h40, 32'h0, 4'b1111, 3'b000, 32'h600DF00D, 0);

    doReq("sw30_zero", 0, 1, 32'h30, 32'h0, 4'b1111, 3'b000, 32'h0, 0);
    mem_write = 1'b1; addr = 32'h30; wdata = 32'h55; be = 4'b1111; ext_sh = 3'b000;
    @(negedge clk);
    chk("abort idle_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1; mem_write = 1'b0;
    @(negedge clk);
    chk("abort reset_stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    modelRdata = 32'h0;
    $display("txn %-14s reset applied in second BUSY cycle", "sw30_abort");
    doReq("lw30_after", 1, 0, 32'h30, 32'h0, 4'b1111, 3'b000, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
